// File: rtl/life_cell_gen.sv
// Single cellular-automaton cell with a generic birth/survive rule and optional
// multi-state decay (Generations rules). Tracks consecutive alive generations.
module life_cell_gen #(
   parameter int N_NEIGHBORS = 8,
   parameter int N_STATES    = 2,
   parameter int AGE_W       = 4,
   localparam int CNT_W      = $clog2(N_NEIGHBORS + 1),
   localparam int SW_RAW     = $clog2(N_STATES),
   localparam int STATE_W    = (SW_RAW < 1) ? 1 : SW_RAW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   load,
   input  logic                   state_0,
   input  logic [N_NEIGHBORS:0]   birth_mask,
   input  logic [N_NEIGHBORS:0]   survive_mask,
   input  logic [N_NEIGHBORS-1:0] neighbors,
   output logic [CNT_W-1:0]       count,
   output logic [STATE_W-1:0]     state_d,
   output logic [STATE_W-1:0]     state_q,
   output logic                   alive,
   output logic [AGE_W-1:0]       age,
   output logic                   changed
);

   localparam logic [STATE_W-1:0] S_DEAD  = '0;
   localparam logic [STATE_W-1:0] S_ALIVE = STATE_W'(1);
   // Two-state rules die straight to 0; otherwise decay starts at state 2.
   localparam logic [STATE_W-1:0] S_DYING = (N_STATES == 2) ? S_DEAD : STATE_W'(2);

   logic [AGE_W-1:0]   age_q, age_d;
   logic               changed_q, changed_d;
   logic               upd;
   logic [STATE_W-1:0] state_nxt;

   always_comb begin
      count = '0;
      for (int i = 0; i < N_NEIGHBORS; i++)
         count = count + CNT_W'(neighbors[i]);
   end

   always_comb begin
      state_d = S_DEAD;
      if (state_q == S_DEAD)
         state_d = birth_mask[count] ? S_ALIVE : S_DEAD;
      else if (state_q == S_ALIVE)
         state_d = survive_mask[count] ? S_ALIVE : S_DYING;
      else if (int'(state_q) < N_STATES - 1)
         state_d = state_q + S_ALIVE;
   end

   // Age counts ena-driven stays in state 1; any entry into state 1 restarts at 0.
   always_comb begin
      upd       = load | ena;
      state_nxt = load ? STATE_W'(state_0) : state_d;
      age_d     = age_q;
      changed_d = 1'b0;
      if (upd) begin
         changed_d = (state_nxt != state_q);
         if (state_nxt != S_ALIVE || load || state_q != S_ALIVE)
            age_d = '0;
         else if (age_q != {AGE_W{1'b1}})
            age_d = age_q + AGE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_DEAD;
         age_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         if (load)
            state_q <= STATE_W'(state_0);
         else if (ena)
            state_q <= state_d;
         age_q     <= age_d;
         changed_q <= changed_d;
      end
   end

   assign alive   = (state_q == S_ALIVE);
   assign age     = age_q;
   assign changed = changed_q;

endmodule
